bin_frame_sink: RTL and testbench

Consumer end of the binarization pipeline's write stream. It accepts thresholded pixels (0/255) on the write-enable strobe, packs them 8-per-byte into an internal frame buffer, and on end-of-frame streams the packed bitmap out over a valid/ready interface. It sits directly downstream of the thresholding mux and controller, and captures `we` / `dataEncoded` / `finallydone`.

---
 rtl/bin_pkg.sv | 20 ++
 rtl/bin_frame_sink_if.sv | 26 ++
 rtl/bin_pack_ram.sv | 30 +++
 rtl/bin_frame_sink.sv | 168 ++++++++++++++++
 tb/tb_bin_frame_sink.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bin_pkg.sv
// Shared definitions for the binarization pipeline's frame sink.
//   state_t : sink FSM states
//   PIX_W   : width of a thresholded pixel
//   PIX_FG  : foreground pixel value (bit 1)
//   PIX_BG  : background pixel value (bit 0)
package bin_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  localparam int PIX_W = 8;
  localparam logic [PIX_W-1:0] PIX_FG = 8'd255;
  localparam logic [PIX_W-1:0] PIX_BG = 8'd0;

endpackage

// File: rtl/bin_frame_sink_if.sv
// Stream bundle of bin_frame_sink.
//   Pixel side : we, pixel_in, frame_done (driven by the upstream controller)
//   Byte side  : out_data, out_valid, out_last (to downstream), out_ready (from downstream)
// Modports: slave = the sink itself, master = the environment around it.
interface bin_frame_sink_if;
  import bin_pkg::*;

  logic             we;
  logic [PIX_W-1:0] pixel_in;
  logic             frame_done;
  logic [PIX_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport slave (
    input  we, pixel_in, frame_done, out_ready,
    output out_data, out_valid, out_last
  );

  modport master (
    output we, pixel_in, frame_done, out_ready,
    input  out_data, out_valid, out_last
  );

endinterface

// File: rtl/bin_pack_ram.sv
// Packed-byte frame buffer: one write port, one read port, synchronous read
// with one cycle of latency. rd_data holds its value when rd_en is low, which
// the sink relies on as a second buffering slot during output stalls.
//   clk              : clock
//   wr_en/addr/data  : byte write
//   rd_en/addr       : read request
//   rd_data          : read data, valid the cycle after rd_en
module bin_pack_ram
  import bin_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bin_frame_sink.sv
// Consumer end of the binarization write stream. Thresholded pixels are
// packed 8 per byte (earliest pixel in bit 0) into a frame buffer; on
// end-of-frame the packed bitmap is streamed out over valid/ready.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus          : pixel input and byte output stream (bin_frame_sink_if.slave)
//   sink_done    : one-cycle pulse after the final byte is accepted
//   overflow     : sticky, a pixel was dropped
//   byte_count   : bytes stored in the current frame
//   fg_count     : foreground pixels in the current frame
// Optional feature: define BIN_FRAME_SINK_FGCOUNT_EN to build fg_count.
module bin_frame_sink
  import bin_pkg::*;
#(
  parameter int NUM_PIXELS = 4096
) (
  input  logic                                clk,
  input  logic                                rst_n,
  bin_frame_sink_if.slave                     bus,
  output logic                                sink_done,
  output logic                                overflow,
  output logic [$clog2(NUM_PIXELS/8+1)-1:0]   byte_count
`ifdef BIN_FRAME_SINK_FGCOUNT_EN
  ,
  output logic [$clog2(NUM_PIXELS+1)-1:0]     fg_count
`endif
);

  localparam int BUF_DEPTH = NUM_PIXELS / 8;
  localparam int AW        = $clog2(BUF_DEPTH);
  localparam int BC_W      = $clog2(BUF_DEPTH + 1);

  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q;
  logic [PIX_W-1:0] pack_q, pack_nx;
  logic [BC_W-1:0]  rd_addr_q;
  logic             pix_bit, full, accept, drop, pending;
  logic             wr_en, rd_en, out_free;
  logic [PIX_W-1:0] wr_data, rd_data;
  logic             vld_p1, last_p1;
  logic             out_valid_q, out_last_q;
  logic [PIX_W-1:0] out_data_q;

  // Only the MSB carries the thresholded bit.
  logic unused_pix_bits;
  assign unused_pix_bits = &{1'b0, bus.pixel_in[PIX_W-2:0]};

  assign pix_bit  = bus.pixel_in[PIX_W-1];
  assign full     = (byte_count == BC_W'(BUF_DEPTH));
  assign accept   = bus.we && (state_q == IDLE || state_q == FILL) && !full;
  assign drop     = bus.we && !accept;
  assign out_free = !out_valid_q || bus.out_ready;

  // Starting a new byte clears the stale high bits, so a flushed partial
  // byte is zero-padded without extra logic.
  assign pack_nx = (bit_cnt_q == 3'd0) ? PIX_W'(pix_bit)
                                       : (pack_q | (PIX_W'(pix_bit) << bit_cnt_q));

  // A partial byte is still pending after this cycle's pixel (if any).
  assign pending = accept ? (bit_cnt_q != 3'd7) : (bit_cnt_q != 3'd0);

  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    wr_data   = pack_nx;
    rd_en     = 1'b0;
    sink_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_en = accept && (bit_cnt_q == 3'd7);
        if (bus.frame_done)  state_d = accept ? FLUSH : DONE;
        else if (accept)     state_d = FILL;
      end
      FILL: begin
        wr_en = accept && (bit_cnt_q == 3'd7);
        if (bus.frame_done) state_d = pending ? FLUSH : DRAIN;
      end
      FLUSH: begin
        wr_en   = 1'b1;
        wr_data = pack_q;
        state_d = DRAIN;
      end
      DRAIN: begin
        // Prefetch while either the RAM output slot is free or the output
        // register is about to take it.
        rd_en = (rd_addr_q < byte_count) && (!vld_p1 || out_free);
        if (out_valid_q && bus.out_ready && out_last_q) state_d = DONE;
      end
      DONE: begin
        sink_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      byte_count  <= '0;
      overflow    <= 1'b0;
      rd_addr_q   <= '0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= PIX_BG;
    end else begin
      state_q <= state_d;
      if (drop) overflow <= 1'b1;
      if (state_q == DONE) begin
        bit_cnt_q  <= 3'd0;
        byte_count <= '0;
        rd_addr_q  <= '0;
      end else begin
        if (accept) bit_cnt_q  <= bit_cnt_q + 3'd1;
        if (wr_en)  byte_count <= byte_count + BC_W'(1);
        if (rd_en)  rd_addr_q  <= rd_addr_q + BC_W'(1);
      end
      // p1: RAM output stage
      if (rd_en) begin
        vld_p1  <= 1'b1;
        last_p1 <= (rd_addr_q == byte_count - BC_W'(1));
      end else if (out_free) begin
        vld_p1  <= 1'b0;
      end
      // p2: output register, held while stalled
      if (out_free) begin
        out_valid_q <= vld_p1;
        out_last_q  <= vld_p1 && last_p1;
        if (vld_p1) out_data_q <= rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pack_q <= pack_nx;
  end

`ifdef BIN_FRAME_SINK_FGCOUNT_EN
  localparam int FG_W = $clog2(NUM_PIXELS + 1);

  always_ff @(posedge clk) begin
    if (!rst_n)                fg_count <= '0;
    else if (state_q == DONE)  fg_count <= '0;
    else if (accept && pix_bit && fg_count != FG_W'(NUM_PIXELS))
                               fg_count <= fg_count + FG_W'(1);
  end
`endif

  bin_pack_ram #(
    .DEPTH (BUF_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (AW'(byte_count)),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (AW'(rd_addr_q)),
    .rd_data (rd_data)
  );

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_bin_frame_sink.sv
// Testbench for bin_frame_sink (NUM_PIXELS = 64). Expected packed bytes are
// built from the generated pixel stream and queued; a negedge monitor pops
// and compares them on every output handshake.
module tb_bin_frame_sink;
  import bin_pkg::*;

  localparam int NP = 64;
  localparam int BD = NP / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sink_done, overflow;
  logic [$clog2(BD+1)-1:0] byte_count;
`ifdef BIN_FRAME_SINK_FGCOUNT_EN
  logic [$clog2(NP+1)-1:0] fg_count;
`endif

  bin_frame_sink_if bus ();

  bin_frame_sink #(.NUM_PIXELS(NP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sink_done  (sink_done),
    .overflow   (overflow),
    .byte_count (byte_count)
`ifdef BIN_FRAME_SINK_FGCOUNT_EN
    ,
    .fg_count   (fg_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int ready_mode = 0;
  int rdy_idx = 0;
  int exp_fg = 0;
  logic [8:0] sb[$];
  logic [7:0] pix_q[$];
  logic [8:0] mon_exp;

  // out_ready: 0 = always 1, 1 = pattern 1,0,0,1, 2 = always 0
  always @(posedge clk) begin
    #1;
    rdy_idx = rdy_idx + 1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
      default: bus.out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt = hs_cnt + 1;
        total = total + 1;
        if (sb.size() == 0) begin
          bad = bad + 1;
          $display("FAIL extra_byte got=%0h required=none", {bus.out_last, bus.out_data});
        end else begin
          mon_exp = sb.pop_front();
          if ({bus.out_last, bus.out_data} !== mon_exp) begin
            bad = bad + 1;
            $display("FAIL out_byte got last/data=%0h required=%0h", {bus.out_last, bus.out_data}, mon_exp);
          end
        end
      end else if (bus.out_valid && sb.size() > 0) begin
        total = total + 1;
        if (bus.out_data !== sb[0][7:0]) begin
          bad = bad + 1;
          $display("FAIL stall_hold got=%0h required=%0h", bus.out_data, sb[0][7:0]);
        end
      end
    end
  end

  // Builds the pixel stream and queues the expected bytes for it.
  task automatic gen_frame(input int n, input int mode);
    logic [7:0] p, acc;
    int acc_n, nbytes;
    pix_q.delete();
    exp_fg = 0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       p = (i % 2 == 0) ? PIX_FG : PIX_BG;
        1:       p = PIX_FG;
        2:       p = PIX_BG;
        default: p = ($urandom_range(0, 1) != 0) ? PIX_FG : PIX_BG;
      endcase
      pix_q.push_back(p);
    end
    acc_n  = (n > NP) ? NP : n;
    nbytes = (acc_n + 7) / 8;
    for (int b = 0; b < nbytes; b++) begin
      acc = 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (b * 8 + k < acc_n) begin
          acc[k] = pix_q[b*8+k][7];
          if (pix_q[b*8+k][7]) exp_fg = exp_fg + 1;
        end
      end
      sb.push_back({(b == nbytes - 1), acc});
    end
  endtask

  task automatic drive_pixels(input bit fd_last);
    for (int i = 0; i < pix_q.size(); i++) begin
      bus.we = 1'b1;
      bus.pixel_in = pix_q[i];
      bus.frame_done = fd_last && (i == pix_q.size() - 1);
      @(posedge clk); #1;
    end
    bus.we = 1'b0;
    bus.frame_done = 1'b0;
  endtask

  task automatic drive_fd();
    bus.frame_done = 1'b1;
    @(posedge clk); #1;
    bus.frame_done = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (sink_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.we = 1'b0; bus.pixel_in = 8'h00; bus.frame_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total = total + 6;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b required=0", bus.out_valid); end
    if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b required=0", bus.out_last); end
    if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%0h required=0", bus.out_data); end
    if (sink_done !== 1'b0) begin bad++; $display("FAIL rst_sink_done got=%b required=0", sink_done); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b required=0", overflow); end
    if (byte_count !== '0) begin bad++; $display("FAIL rst_byte_count got=%0d required=0", byte_count); end
`ifdef BIN_FRAME_SINK_FGCOUNT_EN
    total = total + 1;
    if (fg_count !== '0) begin bad++; $display("FAIL rst_fg_count got=%0d required=0", fg_count); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Common tail: bounded wait for sink_done, one-cycle pulse, counters cleared.
  task automatic finish_frame(input string name);
    bit ok;
    wait_done(ok);
    total = total + 1;
    if (ok !== 1'b1) begin bad++; $display("FAIL %s_sink_done got=timeout required=pulse", name); end
    @(negedge clk);
    total = total + 3;
    if (sink_done !== 1'b0) begin bad++; $display("FAIL %s_pulse_width got=%b required=0", name, sink_done); end
    if (byte_count !== '0) begin bad++; $display("FAIL %s_count_clear got=%0d required=0", name, byte_count); end
    if (sb.size() != 0) begin bad++; $display("FAIL %s_bytes_left got=%0d required=0", name, sb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_alternating();
    ready_mode = 0;
    gen_frame(16, 0);
    drive_pixels(1'b0);
    total = total + 1;
    if (byte_count !== 2) begin bad++; $display("FAIL alt_byte_count got=%0d required=2", byte_count); end
`ifdef BIN_FRAME_SINK_FGCOUNT_EN
    total = total + 1;
    if (fg_count !== 8) begin bad++; $display("FAIL alt_fg_count got=%0d required=8", fg_count); end
`endif
    drive_fd();
    finish_frame("alt");
  endtask

  task automatic test_partial();
    ready_mode = 0;
    gen_frame(11, 1);
    drive_pixels(1'b0);
    drive_fd();
    @(posedge clk);
    @(negedge clk);
    total = total + 1;
    if (byte_count !== 2) begin bad++; $display("FAIL partial_byte_count got=%0d required=2", byte_count); end
    finish_frame("partial");
  endtask

  task automatic test_stall();
    ready_mode = 1;
    gen_frame(8, 3);
    drive_pixels(1'b0);
    drive_fd();
    finish_frame("stall8");
    gen_frame(24, 3);
    drive_pixels(1'b0);
    drive_fd();
    finish_frame("stall24");
    ready_mode = 0;
  endtask

  task automatic test_empty();
    int h0;
    h0 = hs_cnt;
    drive_fd();
    @(negedge clk);
    total = total + 1;
    if (sink_done !== 1'b1) begin bad++; $display("FAIL empty_sink_done got=%b required=1", sink_done); end
    @(negedge clk);
    total = total + 2;
    if (sink_done !== 1'b0) begin bad++; $display("FAIL empty_pulse_width got=%b required=0", sink_done); end
    if (hs_cnt !== h0) begin bad++; $display("FAIL empty_bytes got=%0d required=0", hs_cnt - h0); end
    @(posedge clk); #1;
  endtask

  task automatic test_same_cycle();
    ready_mode = 0;
    gen_frame(8, 3);
    drive_pixels(1'b1);
    @(negedge clk);
    total = total + 2;
    if (byte_count !== 1) begin bad++; $display("FAIL same_byte_count got=%0d required=1", byte_count); end
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL same_valid_early got=%b required=0", bus.out_valid); end
    @(negedge clk);
    total = total + 1;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL same_valid_t1 got=%b required=0", bus.out_valid); end
    @(negedge clk);
    total = total + 1;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL same_valid_t2 got=%b required=1", bus.out_valid); end
    @(posedge clk); #1;
    finish_frame("same");
  endtask

  task automatic test_overflow();
    int h0;
    ready_mode = 0;
    h0 = hs_cnt;
    gen_frame(NP + 3, 3);
    drive_pixels(1'b0);
    total = total + 2;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b required=1", overflow); end
    if (byte_count !== BD) begin bad++; $display("FAIL ovf_byte_count got=%0d required=%0d", byte_count, BD); end
    drive_fd();
    finish_frame("ovf");
    total = total + 2;
    if (hs_cnt - h0 !== BD) begin bad++; $display("FAIL ovf_drained got=%0d required=%0d", hs_cnt - h0, BD); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b required=1", overflow); end
  endtask

  task automatic test_reset_mid_drain();
    ready_mode = 2;
    gen_frame(16, 3);
    drive_pixels(1'b0);
    drive_fd();
    repeat (5) @(posedge clk);
    @(negedge clk);
    total = total + 1;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_valid got=%b required=1", bus.out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    total = total + 6;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b required=0", bus.out_valid); end
    if (bus.out_last !== 1'b0) begin bad++; $display("FAIL mid_out_last got=%b required=0", bus.out_last); end
    if (bus.out_data !== 8'h00) begin bad++; $display("FAIL mid_out_data got=%0h required=0", bus.out_data); end
    if (sink_done !== 1'b0) begin bad++; $display("FAIL mid_sink_done got=%b required=0", sink_done); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%b required=0", overflow); end
    if (byte_count !== '0) begin bad++; $display("FAIL mid_byte_count got=%0d required=0", byte_count); end
    ready_mode = 0;
    gen_frame(8, 2);
    drive_pixels(1'b0);
    drive_fd();
    finish_frame("after_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alternating();
    test_partial();
    test_stall();
    test_empty();
    test_same_cycle();
    test_overflow();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
